// File: rtl/mmul_pkg.sv
// Shared types and constant helpers for the streaming matrix multiplier.
// Offsets assume row-major flattening with element 0 in the least significant slot.
package mmul_pkg;

  typedef enum logic [1:0] {
    IDLE,
    MAC,
    DONE
  } state_t;

  function automatic int clog2_int(input int n);
    int r;
    r = 0;
    while ((1 << r) < n) r++;
    return r;
  endfunction

  // Wide enough for N full-scale products plus an accumulated base element.
  function automatic int acc_width(input int width, input int n);
    return 2 * width + clog2_int(n) + 2;
  endfunction

  function automatic int elem_off(input int row, input int col, input int ncols, input int width);
    return (row * ncols + col) * width;
  endfunction

  function automatic longint smax_val(input int width);
    return (longint'(1) <<< (width - 1)) - 1;
  endfunction

  function automatic longint smin_val(input int width);
    return -(longint'(1) <<< (width - 1));
  endfunction

  function automatic longint umax_val(input int width);
    return (longint'(1) <<< width) - 1;
  endfunction

  function automatic longint umin_val(input int width);
    return longint'(width) * 0;
  endfunction

endpackage

// File: rtl/mmul_sat.sv
// Narrows a signed accumulator to WIDTH bits, clamping or wrapping, and
// reports whether the true value lay outside the signed/unsigned range.
module mmul_sat
  import mmul_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int ACC_W = 20
) (
  input  logic signed [ACC_W-1:0] acc,
  input  logic                    signed_mode,
  input  logic                    sat_en,
  output logic        [WIDTH-1:0] result,
  output logic                    ovf
);

  localparam logic signed [ACC_W-1:0] S_MAX = ACC_W'(smax_val(WIDTH));
  localparam logic signed [ACC_W-1:0] S_MIN = ACC_W'(smin_val(WIDTH));
  localparam logic signed [ACC_W-1:0] U_MAX = ACC_W'(umax_val(WIDTH));
  localparam logic signed [ACC_W-1:0] U_MIN = ACC_W'(umin_val(WIDTH));

  // Returns {ovf, result}.
  function automatic logic [WIDTH:0] saturate(input logic signed [ACC_W-1:0] v,
                                              input logic sm, input logic se);
    logic signed [ACC_W-1:0] lo;
    logic signed [ACC_W-1:0] hi;
    logic                    o;
    logic        [WIDTH-1:0] r;
    lo = sm ? S_MIN : U_MIN;
    hi = sm ? S_MAX : U_MAX;
    o  = (v < lo) || (v > hi);
    r  = v[WIDTH-1:0];
    if (se && (v < lo)) r = lo[WIDTH-1:0];
    else if (se && (v > hi)) r = hi[WIDTH-1:0];
    return {o, r};
  endfunction

  assign {ovf, result} = saturate(acc, signed_mode, sat_en);

endmodule

// File: rtl/mmul_stream.sv
// Streaming C = A x B (or C += A x B) using one shared MAC, one product per clock,
// with valid/ready handshakes on both sides and a sticky overflow flag.
module mmul_stream
  import mmul_pkg::*;
#(
  parameter int M     = 3,
  parameter int N     = 3,
  parameter int K     = 3,
  parameter int L     = 3,
  parameter int WIDTH = 8
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [M*N*WIDTH-1:0]   mat_a,
  input  logic [K*L*WIDTH-1:0]   mat_b,
  input  logic                   signed_mode,
  input  logic                   sat_en,
  input  logic                   acc_mode,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [M*L*WIDTH-1:0]   mat_axb,
  output logic                   overflow,
  output logic                   invalid
);

  localparam int   ACC_W     = acc_width(WIDTH, N);
  localparam int   IW        = (M > 1) ? $clog2(M) : 1;
  localparam int   JW        = (L > 1) ? $clog2(L) : 1;
  localparam int   KW        = (N > 1) ? $clog2(N) : 1;
  localparam logic VALID_CFG = (N == K);

  state_t state;
  logic [IW-1:0] i_q;
  logic [JW-1:0] j_q;
  logic [KW-1:0] k_q;

  logic [M*N*WIDTH-1:0] a_p0;
  logic [K*L*WIDTH-1:0] b_p0;
  logic                 sgn_p0;
  logic                 sat_p0;
  logic                 accm_p0;
  logic signed [ACC_W-1:0] acc_p1;

  logic        [WIDTH-1:0] a_el, b_el, c_el, sat_res;
  logic signed [ACC_W-1:0] a_ext, b_ext, c_ext, base, prod, acc_next;
  logic                    sat_ovf;
  logic                    last_k, last_j, last_i;

  assign invalid = !VALID_CFG;
  assign last_k  = (k_q == KW'(N - 1));
  assign last_j  = (j_q == JW'(L - 1));
  assign last_i  = (i_q == IW'(M - 1));

  function automatic logic signed [ACC_W-1:0] ext(input logic [WIDTH-1:0] v, input logic sm);
    return sm ? {{(ACC_W-WIDTH){v[WIDTH-1]}}, v} : {{(ACC_W-WIDTH){1'b0}}, v};
  endfunction

  // MAC stage: operand select, extend, multiply, accumulate.
  always_comb begin
    a_el     = a_p0[elem_off(int'(i_q), int'(k_q), N, WIDTH) +: WIDTH];
    b_el     = b_p0[elem_off(int'(k_q), int'(j_q), L, WIDTH) +: WIDTH];
    c_el     = mat_axb[elem_off(int'(i_q), int'(j_q), L, WIDTH) +: WIDTH];
    a_ext    = ext(a_el, sgn_p0);
    b_ext    = ext(b_el, sgn_p0);
    c_ext    = ext(c_el, sgn_p0);
    base     = accm_p0 ? c_ext : '0;
    prod     = a_ext * b_ext;
    acc_next = (k_q == '0 ? base : acc_p1) + prod;
  end

  mmul_sat #(
    .WIDTH(WIDTH),
    .ACC_W(ACC_W)
  ) u_sat (
    .acc        (acc_next),
    .signed_mode(sgn_p0),
    .sat_en     (sat_p0),
    .result     (sat_res),
    .ovf        (sat_ovf)
  );

  // Operand capture and running sum carry no reset; they are always rewritten before use.
  always_ff @(posedge clk) begin
    if (state == IDLE && in_valid && in_ready) begin
      a_p0    <= mat_a;
      b_p0    <= mat_b;
      sgn_p0  <= signed_mode;
      sat_p0  <= sat_en;
      accm_p0 <= acc_mode;
    end
    if (state == MAC) acc_p1 <= acc_next;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= IDLE;
      in_ready  <= VALID_CFG;
      out_valid <= 1'b0;
      overflow  <= 1'b0;
      mat_axb   <= '0;
      i_q       <= '0;
      j_q       <= '0;
      k_q       <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid && in_ready) begin
            in_ready <= 1'b0;
            overflow <= 1'b0;
            i_q      <= '0;
            j_q      <= '0;
            k_q      <= '0;
            state    <= MAC;
          end
        end
        MAC: begin
          if (last_k) begin
            mat_axb[elem_off(int'(i_q), int'(j_q), L, WIDTH) +: WIDTH] <= sat_res;
            overflow <= overflow | sat_ovf;
            k_q      <= '0;
            if (last_j) begin
              j_q <= '0;
              if (last_i) begin
                i_q       <= '0;
                out_valid <= 1'b1;
                state     <= DONE;
              end else begin
                i_q <= i_q + 1'b1;
              end
            end else begin
              j_q <= j_q + 1'b1;
            end
          end else begin
            k_q <= k_q + 1'b1;
          end
        end
        DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            in_ready  <= VALID_CFG;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mmul_stream.sv
// Bench for mmul_stream: fixed vector table, handshake/reset sequences,
// an N != K instance, and random operations against an arithmetic model.
module tb_mmul_stream;
  localparam int W  = 8;
  localparam int MW = 9 * W;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [MW-1:0] mat_a = '0;
  logic [MW-1:0] mat_b = '0;
  logic          signed_mode = 1'b0;
  logic          sat_en = 1'b0;
  logic          acc_mode = 1'b0;
  logic          out_valid;
  logic          out_ready = 1'b0;
  logic [MW-1:0] mat_axb;
  logic          overflow;
  logic          invalid;

  logic          bad_in_valid = 1'b0;
  logic          bad_in_ready;
  logic [6*W-1:0] bad_b = '0;
  logic          bad_out_valid;
  logic [MW-1:0] bad_axb;
  logic          bad_overflow;
  logic          bad_invalid;

  int vec_cnt = 0;
  int err_cnt = 0;
  logic [MW-1:0] model_c = '0;

  always #5 clk = ~clk;

  mmul_stream #(.M(3), .N(3), .K(3), .L(3), .WIDTH(W)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .mat_a(mat_a), .mat_b(mat_b), .signed_mode(signed_mode), .sat_en(sat_en),
    .acc_mode(acc_mode), .out_valid(out_valid), .out_ready(out_ready),
    .mat_axb(mat_axb), .overflow(overflow), .invalid(invalid)
  );

  mmul_stream #(.M(3), .N(3), .K(2), .L(3), .WIDTH(W)) dut_bad (
    .clk(clk), .reset(reset), .in_valid(bad_in_valid), .in_ready(bad_in_ready),
    .mat_a(mat_a), .mat_b(bad_b), .signed_mode(1'b0), .sat_en(1'b1),
    .acc_mode(1'b0), .out_valid(bad_out_valid), .out_ready(1'b1),
    .mat_axb(bad_axb), .overflow(bad_overflow), .invalid(bad_invalid)
  );

  typedef struct {
    logic [MW-1:0] a;
    logic [MW-1:0] b;
    bit            sgn;
    bit            sat;
    bit            acc;
    logic [MW-1:0] exp_c;
    bit            exp_ovf;
  } vec_t;

  vec_t vecs[7];

  task automatic check(input string name, input logic [MW-1:0] got, input logic [MW-1:0] exp);
    vec_cnt++;
    if (got !== exp) begin
      err_cnt++;
      $display("FAIL %s: got %h required %h", name, got, exp);
    end
  endtask

  function automatic longint ev(input logic [MW-1:0] m, input int idx, input bit sgn);
    logic [W-1:0] e;
    e = m[idx*W +: W];
    if (sgn) return longint'($signed(e));
    return longint'(e);
  endfunction

  // Plain-arithmetic reference: exact sum, then range check and clamp or truncate.
  function automatic void model(input logic [MW-1:0] a, input logic [MW-1:0] b,
                                input logic [MW-1:0] prev, input bit sgn, input bit sat,
                                input bit acc, output logic [MW-1:0] c, output bit ovf);
    longint s, lo, hi, r;
    ovf = 1'b0;
    c   = '0;
    lo  = sgn ? -128 : 0;
    hi  = sgn ? 127 : 255;
    for (int i = 0; i < 3; i++)
      for (int j = 0; j < 3; j++) begin
        s = acc ? ev(prev, i*3+j, sgn) : 0;
        for (int k = 0; k < 3; k++) s += ev(a, i*3+k, sgn) * ev(b, k*3+j, sgn);
        if (s < lo || s > hi) ovf = 1'b1;
        r = s;
        if (sat && s < lo) r = lo;
        else if (sat && s > hi) r = hi;
        c[(i*3+j)*W +: W] = r[W-1:0];
      end
  endfunction

  task automatic start_op(input logic [MW-1:0] a, input logic [MW-1:0] b,
                          input bit sgn, input bit sat, input bit acc);
    int n = 0;
    @(negedge clk);
    while (!in_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) check("in_ready_wait", {71'd0, in_ready}, 1);
    mat_a = a; mat_b = b; signed_mode = sgn; sat_en = sat; acc_mode = acc;
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid    = 1'b0;
    mat_a       = {$urandom, $urandom, $urandom};
    mat_b       = {$urandom, $urandom, $urandom};
    signed_mode = ~sgn; sat_en = ~sat; acc_mode = ~acc;
  endtask

  task automatic wait_done(output int lat);
    lat = 0;
    while (!out_valid && lat < 200) begin
      @(posedge clk);
      #1;
      lat++;
    end
  endtask

  task automatic handoff();
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    check("handoff_out_valid", {71'd0, out_valid}, 0);
  endtask

  task automatic run_op(input string tag, input logic [MW-1:0] a, input logic [MW-1:0] b,
                        input bit sgn, input bit sat, input bit acc,
                        input logic [MW-1:0] exp_c, input bit exp_ovf);
    int lat;
    start_op(a, b, sgn, sat, acc);
    wait_done(lat);
    check({tag, "_latency"}, MW'(lat), 27);
    @(negedge clk);
    check({tag, "_c"}, mat_axb, exp_c);
    check({tag, "_ovf"}, {71'd0, overflow}, {71'd0, exp_ovf});
    check({tag, "_in_ready"}, {71'd0, in_ready}, 0);
    handoff();
  endtask

  localparam logic [MW-1:0] BASIC_A = {8'd1, 8'd2, 8'd3, 8'd1, 8'd0, 8'd5, 8'd3, 8'd8, 8'd2};
  localparam logic [MW-1:0] BASIC_B = {8'd0, 8'd0, 8'd3, 8'd5, 8'd6, 8'd1, 8'd2, 8'd0, 8'd8};
  localparam logic [MW-1:0] BASIC_C = {8'd16, 8'd12, 8'd29, 8'd10, 8'd0, 8'd43, 8'd44, 8'd48, 8'd33};

  initial begin
    int lat;
    bit stable;
    logic [MW-1:0] snap, exp_c, ra, rb;
    bit exp_ovf, rs, rt, rc;

    vecs[0] = '{BASIC_A, BASIC_B, 0, 1, 0, BASIC_C, 0};
    vecs[1] = '{BASIC_A, BASIC_B, 0, 1, 1,
                {8'd32, 8'd24, 8'd58, 8'd20, 8'd0, 8'd86, 8'd88, 8'd96, 8'd66}, 0};
    vecs[2] = '{BASIC_A, BASIC_B, 0, 1, 1,
                {8'd48, 8'd36, 8'd87, 8'd30, 8'd0, 8'd129, 8'd132, 8'd144, 8'd99}, 0};
    vecs[3] = '{{9{8'hFF}}, {9{8'hFF}}, 0, 1, 0, {9{8'hFF}}, 1};
    vecs[4] = '{{9{8'hFF}}, {9{8'hFF}}, 0, 0, 0, {9{8'h03}}, 1};
    vecs[5] = '{{9{8'hFF}}, {9{8'h02}}, 1, 1, 0, {9{8'hFA}}, 0};
    vecs[6] = '{{9{8'h80}}, {9{8'h80}}, 1, 1, 0, {9{8'h7F}}, 1};

    #12;
    check("reset_out_valid", {71'd0, out_valid}, 0);
    check("reset_in_ready", {71'd0, in_ready}, 1);
    check("reset_c", mat_axb, '0);
    check("reset_ovf", {71'd0, overflow}, 0);
    check("invalid_good_cfg", {71'd0, invalid}, 0);
    @(negedge clk);
    reset = 1'b1;

    for (int v = 0; v < 7; v++) begin
      run_op($sformatf("vec%0d", v), vecs[v].a, vecs[v].b, vecs[v].sgn, vecs[v].sat,
             vecs[v].acc, vecs[v].exp_c, vecs[v].exp_ovf);
      model_c = vecs[v].exp_c;
    end

    // Result must sit still while the consumer stalls.
    start_op(BASIC_A, BASIC_B, 0, 1, 0);
    wait_done(lat);
    check("stall_latency", MW'(lat), 27);
    snap   = mat_axb;
    stable = 1'b1;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      if (!out_valid || in_ready || mat_axb !== snap) stable = 1'b0;
    end
    check("stall_stable", {71'd0, stable}, 1);
    check("stall_c", snap, BASIC_C);
    handoff();

    // Asynchronous reset in the middle of a MAC sweep.
    start_op({9{8'hFF}}, {9{8'hFF}}, 0, 1, 0);
    repeat (12) @(posedge clk);
    #2;
    reset = 1'b0;
    #1;
    check("midreset_out_valid", {71'd0, out_valid}, 0);
    check("midreset_in_ready", {71'd0, in_ready}, 1);
    check("midreset_c", mat_axb, '0);
    check("midreset_ovf", {71'd0, overflow}, 0);
    @(negedge clk);
    reset = 1'b1;
    run_op("after_reset", BASIC_A, BASIC_B, 0, 1, 0, BASIC_C, 0);
    model_c = BASIC_C;

    // N != K instance never accepts.
    check("bad_invalid", {71'd0, bad_invalid}, 1);
    check("bad_in_ready", {71'd0, bad_in_ready}, 0);
    stable = 1'b1;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      bad_in_valid = c[0];
      if (bad_out_valid || bad_in_ready) stable = 1'b0;
    end
    bad_in_valid = 1'b0;
    check("bad_never_valid", {71'd0, stable}, 1);

    for (int r = 0; r < 24; r++) begin
      ra = {$urandom, $urandom, $urandom};
      rb = {$urandom, $urandom, $urandom};
      if (r % 4 == 1) begin
        ra = ra & {9{8'h0F}};
        rb = rb & {9{8'h07}};
      end
      rs = 1'($urandom_range(0, 1));
      rt = 1'($urandom_range(0, 1));
      rc = 1'($urandom_range(0, 1));
      model(ra, rb, model_c, rs, rt, rc, exp_c, exp_ovf);
      run_op($sformatf("rand%0d", r), ra, rb, rs, rt, rc, exp_c, exp_ovf);
      model_c = exp_c;
    end

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule
